// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, mul/div FSM states
// and the default memory-stage bubble bundle.
package execute_stage_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_SLLV  = 5'd11;
  localparam logic [4:0] OP_SRLV  = 5'd12;
  localparam logic [4:0] OP_SRAV  = 5'd13;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MFHI  = 5'd20;
  localparam logic [4:0] OP_MFLO  = 5'd21;
  localparam logic [4:0] OP_MTHI  = 5'd22;
  localparam logic [4:0] OP_MTLO  = 5'd23;

  localparam logic [7:0] MEM_BUBBLE_DEFAULT = 8'h31;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_FIX} md_state_t;

  // Codes 16..23 all touch the mul/div unit or HI/LO.
  function automatic logic is_muldiv_op(input logic [4:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

  // Codes 16..19: op[1] selects divide, op[0] selects unsigned.
  function automatic logic is_start_op(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute inputs and execute-to-memory outputs of the execute stage.
// Handshake: no valid/ready; stall_out=1 freezes the producer and the stage's input registers.
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic [4:0]  alu_op_in;
  logic        alu_src_imm_in;
  logic [31:0] reg_a_in;
  logic [31:0] reg_b_in;
  logic [31:0] imm_in;
  logic [4:0]  shamt_in;
  logic [7:0]  mem_bundle_in;
  logic [4:0]  write_reg_in;
  logic [31:0] pc_seq_in;
  logic [31:0] address_out;
  logic [31:0] reg_b_out;
  logic [7:0]  bundle_out;
  logic [4:0]  write_reg_out;
  logic [31:0] pc_seq_out;
  logic        stall_out;
  md_state_t   muldiv_state;

  modport master (
    output alu_op_in, alu_src_imm_in, reg_a_in, reg_b_in, imm_in, shamt_in,
           mem_bundle_in, write_reg_in, pc_seq_in,
    input  address_out, reg_b_out, bundle_out, write_reg_out, pc_seq_out,
           stall_out, muldiv_state
  );

  modport slave (
    input  alu_op_in, alu_src_imm_in, reg_a_in, reg_b_in, imm_in, shamt_in,
           mem_bundle_in, write_reg_in, pc_seq_in,
    output address_out, reg_b_out, bundle_out, write_reg_out, pc_seq_out,
           stall_out, muldiv_state
  );

endinterface

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit owning HI/LO: shift-add multiply,
// restoring divide on magnitudes, sign fix-up in a final FIX cycle.
module muldiv_unit
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output md_state_t   state
);

  md_state_t   state_next;
  logic [4:0]  count;
  logic [31:0] mcand, acc_hi, acc_lo, hi_q, lo_q;
  logic        is_div, neg_lo, neg_hi, div0;
  logic [31:0] mag_a, mag_b, step_hi, step_lo;
  logic [32:0] mul_top, trial;
  logic        sgn;

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (count == 5'd31) state_next = MD_FIX;
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    sgn     = ~op[0];
    mag_a   = (sgn && a[31]) ? -a : a;
    mag_b   = (sgn && b[31]) ? -b : b;
    mul_top = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
    trial   = {acc_hi, acc_lo[31]};
    if (is_div) begin
      // With a zero divisor both branches leave the dividend in acc_hi.
      if (trial >= {1'b0, mcand}) begin
        step_hi = 32'(trial - {1'b0, mcand});
        step_lo = {acc_lo[30:0], 1'b1};
      end else begin
        step_hi = trial[31:0];
        step_lo = {acc_lo[30:0], 1'b0};
      end
    end else begin
      step_hi = mul_top[32:1];
      step_lo = {mul_top[0], acc_lo[31:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MD_IDLE;
      count  <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        MD_IDLE: begin
          if (start) begin
            is_div <= op[1];
            mcand  <= op[1] ? mag_b : mag_a;
            acc_lo <= op[1] ? mag_a : mag_b;
            acc_hi <= '0;
            neg_lo <= sgn && (a[31] ^ b[31]);
            neg_hi <= op[1] ? (sgn && a[31]) : (sgn && (a[31] ^ b[31]));
            div0   <= op[1] && (b == 32'd0);
            count  <= '0;
          end else begin
            if (mthi) hi_q <= a;
            if (mtlo) lo_q <= a;
          end
        end
        MD_BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 5'd1;
        end
        MD_FIX: begin
          if (is_div) begin
            lo_q <= div0 ? 32'hFFFF_FFFF : (neg_lo ? -acc_lo : acc_lo);
            hi_q <= neg_hi ? -acc_hi : acc_hi;
          end else begin
            {hi_q, lo_q} <= neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != MD_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: input registers, ALU, stall/bubble generation.
// Define MULDIV_EN to build the multiply/divide unit and HI/LO registers.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter logic [7:0] MEM_BUBBLE = MEM_BUBBLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  execute_stage_if.slave bus
);

  logic [4:0]  op_q, shamt_q, wreg_q;
  logic        src_imm_q;
  logic [31:0] a_q, b_q, imm_q, pc_q, opb, result, hi_val, lo_val;
  logic [7:0]  bundle_q;
  logic        stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      src_imm_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
      bundle_q  <= MEM_BUBBLE;
      wreg_q    <= '0;
      pc_q      <= '0;
    end else if (!stall) begin
      op_q      <= bus.alu_op_in;
      src_imm_q <= bus.alu_src_imm_in;
      a_q       <= bus.reg_a_in;
      b_q       <= bus.reg_b_in;
      imm_q     <= bus.imm_in;
      shamt_q   <= bus.shamt_in;
      bundle_q  <= bus.mem_bundle_in;
      wreg_q    <= bus.write_reg_in;
      pc_q      <= bus.pc_seq_in;
    end
  end

`ifdef MULDIV_EN
  logic md_busy;

  // Only HI/LO consumers wait on the unit; plain ALU ops keep flowing.
  assign stall = md_busy && is_muldiv_op(op_q);

  muldiv_unit u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (is_start_op(op_q) && !stall),
    .op    (op_q[1:0]),
    .a     (a_q),
    .b     (opb),
    .mthi  ((op_q == OP_MTHI) && !stall),
    .mtlo  ((op_q == OP_MTLO) && !stall),
    .busy  (md_busy),
    .hi    (hi_val),
    .lo    (lo_val),
    .state (bus.muldiv_state)
  );
`else
  assign stall            = 1'b0;
  assign hi_val           = '0;
  assign lo_val           = '0;
  assign bus.muldiv_state = MD_IDLE;
`endif

  assign opb = src_imm_q ? imm_q : b_q;

  always_comb begin
    result = '0;
    case (op_q)
      OP_ADD:  result = a_q + opb;
      OP_SUB:  result = a_q - opb;
      OP_AND:  result = a_q & opb;
      OP_OR:   result = a_q | opb;
      OP_XOR:  result = a_q ^ opb;
      OP_NOR:  result = ~(a_q | opb);
      OP_SLT:  result = {31'b0, $signed(a_q) < $signed(opb)};
      OP_SLTU: result = {31'b0, a_q < opb};
      OP_SLL:  result = opb << shamt_q;
      OP_SRL:  result = opb >> shamt_q;
      OP_SRA:  result = 32'($signed(opb) >>> shamt_q);
      OP_SLLV: result = opb << a_q[4:0];
      OP_SRLV: result = opb >> a_q[4:0];
      OP_SRAV: result = 32'($signed(opb) >>> a_q[4:0]);
      OP_LUI:  result = {opb[15:0], 16'h0000};
      OP_MFHI: result = hi_val;
      OP_MFLO: result = lo_val;
      default: result = '0;
    endcase
  end

  assign bus.address_out   = result;
  assign bus.reg_b_out     = b_q;
  assign bus.pc_seq_out    = pc_q;
  assign bus.bundle_out    = stall ? MEM_BUBBLE : bundle_q;
  assign bus.write_reg_out = stall ? 5'd0 : wreg_q;
  assign bus.stall_out     = stall;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU vector table plus mul/div, stall and
// reset sequences (selected by MULDIV_EN).
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  execute_stage_if bus();

  execute_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        src_imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t        vecs[NVEC];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic src_imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] shamt,
                       input logic [7:0] bundle, input logic [4:0] wreg, input logic [31:0] pc);
    bus.alu_op_in      = op;
    bus.alu_src_imm_in = src_imm;
    bus.reg_a_in       = a;
    bus.reg_b_in       = b;
    bus.imm_in         = imm;
    bus.shamt_in       = shamt;
    bus.mem_bundle_in  = bundle;
    bus.write_reg_in   = wreg;
    bus.pc_seq_in      = pc;
  endtask

  // Issue a start op (write_reg 0) and check it flows downstream unstalled.
  task automatic start_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    drive(op, 1'b0, a, b, 32'd0, 5'd0, 8'h55, 5'd0, 32'h3000);
    @(negedge clk);
    check({name, "_start_stall"}, 32'(bus.stall_out), 32'd0);
    check({name, "_start_bundle"}, 32'(bus.bundle_out), 32'h55);
  endtask

  // Issue MFHI/MFLO, count stalled cycles (bubble checked each one), then check result.
  task automatic read_hilo(input string name, input logic [4:0] op, input logic [31:0] exp,
                           input int exp_stall);
    int n;
    drive(op, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 8'h66, 5'd9, 32'h2000);
    @(negedge clk);
    n = 0;
    while (bus.stall_out === 1'b1 && n < 40) begin
      check({name, "_bubble_bundle"}, 32'(bus.bundle_out), 32'h31);
      check({name, "_bubble_wreg"}, 32'(bus.write_reg_out), 32'd0);
      @(negedge clk);
      n++;
    end
    check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check(name, bus.address_out, exp);
    check({name, "_bundle"}, 32'(bus.bundle_out), 32'h66);
    check({name, "_wreg"}, 32'(bus.write_reg_out), 32'd9);
  endtask

  task automatic run_adds(input string name, input int count, input int seed);
    logic [31:0] a, b;
    for (int i = 0; i < count; i++) begin
      a = 32'(i + seed) * 32'h0101_0101;
      b = 32'hFFFF_0000 + 32'(i);
      drive(OP_ADD, 1'b0, a, b, 32'd0, 5'd0, 8'h77, 5'd3, 32'h4000 + 32'(4 * i));
      exp_q.push_back(a + b);
      @(negedge clk);
      check($sformatf("%s%0d_stall", name, i), 32'(bus.stall_out), 32'd0);
      check($sformatf("%s%0d_addr", name, i), bus.address_out, exp_q.pop_front());
    end
  endtask

  initial begin
    vecs[0]  = '{OP_ADD,  1'b0, 32'h7FFF_FFFF, 32'd1,          32'd0,          5'd0,  32'h8000_0000};
    vecs[1]  = '{OP_ADD,  1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0,          5'd0,  32'h0000_0000};
    vecs[2]  = '{OP_SUB,  1'b0, 32'd5,         32'd7,          32'd0,          5'd0,  32'hFFFF_FFFE};
    vecs[3]  = '{OP_AND,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'd0,          5'd0,  32'hF000_F000};
    vecs[4]  = '{OP_OR,   1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'd0,          5'd0,  32'hFFF0_FFF0};
    vecs[5]  = '{OP_XOR,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'd0,          5'd0,  32'h0FF0_0FF0};
    vecs[6]  = '{OP_NOR,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'd0,          5'd0,  32'h000F_000F};
    vecs[7]  = '{OP_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0,          5'd0,  32'd1};
    vecs[8]  = '{OP_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0,          5'd0,  32'd0};
    vecs[9]  = '{OP_SLL,  1'b0, 32'hDEAD_BEEF, 32'd1,          32'd0,          5'd31, 32'h8000_0000};
    vecs[10] = '{OP_SRL,  1'b0, 32'd0,         32'h8000_0000,  32'd0,          5'd4,  32'h0800_0000};
    vecs[11] = '{OP_SRA,  1'b0, 32'd0,         32'h8000_0000,  32'd0,          5'd4,  32'hF800_0000};
    vecs[12] = '{OP_SLLV, 1'b0, 32'hFFFF_FFE4, 32'd3,          32'd0,          5'd9,  32'h0000_0030};
    vecs[13] = '{OP_SRLV, 1'b0, 32'd8,         32'hF000_0000,  32'd0,          5'd0,  32'h00F0_0000};
    vecs[14] = '{OP_SRAV, 1'b0, 32'd8,         32'hF000_0000,  32'd0,          5'd0,  32'hFFF0_0000};
    vecs[15] = '{OP_LUI,  1'b1, 32'd0,         32'h0000_FFFF,  32'h0000_1234,  5'd0,  32'h1234_0000};
    vecs[16] = '{OP_ADD,  1'b1, 32'h10,        32'h0000_0100,  32'hFFFF_FFFF,  5'd0,  32'h0000_000F};
    vecs[17] = '{5'd15,   1'b0, 32'd1,         32'd2,          32'd0,          5'd0,  32'd0};
    vecs[18] = '{5'd24,   1'b0, 32'd1,         32'd2,          32'd0,          5'd0,  32'd0};
    vecs[19] = '{5'd31,   1'b0, 32'd1,         32'd2,          32'd0,          5'd0,  32'd0};

    // Reset held two cycles with non-zero inputs present.
    reset = 1'b1;
    drive(OP_ADD, 1'b0, 32'd5, 32'd6, 32'd7, 5'd3, 8'hAA, 5'd7, 32'h100);
    @(negedge clk);
    @(negedge clk);
    check("rst_addr", bus.address_out, 32'd0);
    check("rst_reg_b", bus.reg_b_out, 32'd0);
    check("rst_bundle", 32'(bus.bundle_out), 32'h31);
    check("rst_wreg", 32'(bus.write_reg_out), 32'd0);
    check("rst_pc", bus.pc_seq_out, 32'd0);
    check("rst_stall", 32'(bus.stall_out), 32'd0);
    check("rst_state", 32'(bus.muldiv_state), 32'(MD_IDLE));
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].op, vecs[i].src_imm, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].shamt,
            8'h40 + 8'(i), 5'(i + 1), 32'h100 + 32'(4 * i));
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d_addr", i), bus.address_out, exp_q.pop_front());
      check($sformatf("vec%0d_reg_b", i), bus.reg_b_out, vecs[i].b);
      check($sformatf("vec%0d_bundle", i), 32'(bus.bundle_out), 32'h40 + 32'(i));
      check($sformatf("vec%0d_wreg", i), 32'(bus.write_reg_out), 32'(i + 1));
      check($sformatf("vec%0d_pc", i), bus.pc_seq_out, 32'h100 + 32'(4 * i));
      check($sformatf("vec%0d_stall", i), 32'(bus.stall_out), 32'd0);
    end

`ifdef MULDIV_EN
    start_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    read_hilo("mult_lo", OP_MFLO, 32'hFFFF_FFEB, 33);
    read_hilo("mult_hi", OP_MFHI, 32'hFFFF_FFFF, 0);
    start_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    read_hilo("div_lo", OP_MFLO, 32'hFFFF_FFFD, 33);
    read_hilo("div_hi", OP_MFHI, 32'hFFFF_FFFF, 0);
    start_op("divu0", OP_DIVU, 32'd5, 32'd0);
    read_hilo("divu0_lo", OP_MFLO, 32'hFFFF_FFFF, 33);
    read_hilo("divu0_hi", OP_MFHI, 32'd5, 0);
    drive(OP_MTHI, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 5'd0, 8'h11, 5'd0, 32'h0);
    @(negedge clk);
    read_hilo("mthi", OP_MFHI, 32'h1234_5678, 0);
    drive(OP_MTLO, 1'b0, 32'h8765_4321, 32'd0, 32'd0, 5'd0, 8'h11, 5'd0, 32'h0);
    @(negedge clk);
    read_hilo("mtlo", OP_MFLO, 32'h8765_4321, 0);
`else
    start_op("nomd_mult", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    read_hilo("nomd_lo", OP_MFLO, 32'd0, 0);
    drive(OP_MTHI, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 5'd0, 8'h11, 5'd0, 32'h0);
    @(negedge clk);
    read_hilo("nomd_hi", OP_MFHI, 32'd0, 0);
`endif

    // Independent ALU ops flow while the unit works in the background.
    start_op("multu", OP_MULTU, 32'd3, 32'd4);
    run_adds("bg_add", 20, 1);
`ifdef MULDIV_EN
    read_hilo("multu_lo", OP_MFLO, 32'd12, 13);
`else
    read_hilo("multu_lo", OP_MFLO, 32'd0, 0);
`endif

    // Reset mid-operation aborts the unit and clears HI/LO.
    start_op("abort", OP_MULTU, 32'd5, 32'd6);
    run_adds("abort_add", 9, 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_stall", 32'(bus.stall_out), 32'd0);
    check("abort_state", 32'(bus.muldiv_state), 32'(MD_IDLE));
    check("abort_bundle", 32'(bus.bundle_out), 32'h31);
    read_hilo("abort_lo", OP_MFLO, 32'd0, 0);
    read_hilo("abort_hi", OP_MFHI, 32'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipeline execute stage: registers operands and control from decode, computes the ALU result, and feeds the memory stage its `address_in`, `reg_b_in`, `bundle_in`, `write_reg_in` and `pc_seq_in`. It owns the HI/LO registers and an iterative multiply/divide unit. It also raises a stall to upstream stages when an instruction needs a busy multiply/divide unit.

## Interface
Parameters:
- `MEM_BUBBLE`, default 8'h31: memory-stage control bundle emitted for a bubble; also the reset value of `bundle_out`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `alu_op_in`  in  5  operation code; encodings are in the Operation section
- `alu_src_imm_in`  in  1  1 = operand B is `imm_in`, 0 = operand B is `reg_b_in`
- `reg_a_in`  in  32  rs value
- `reg_b_in`  in  32  rt value
- `imm_in`  in  32  immediate, already extended by decode
- `shamt_in`  in  5  shift amount
- `mem_bundle_in`  in  8  memory-stage control bundle, passed through
- `write_reg_in`  in  5  destination register
- `pc_seq_in`  in  32  PC+4
- `address_out`  out  32  ALU result (memory address or writeback value)
- `reg_b_out`  out  32  registered rt value (store data)
- `bundle_out`  out  8  memory-stage control bundle
- `write_reg_out`  out  5  destination register
- `pc_seq_out`  out  32  registered PC+4
- `stall_out`  out  1  holds upstream stages and this stage's input registers

## Operation
- All inputs are captured in input registers on every `clk` where `stall_out`=0. Outputs are combinational from those registers and from HI/LO.
- Operand B = `alu_src_imm_in` ? `imm_in` : `reg_b_in`.
- `alu_op` encodings and results:
  - 0 ADD: A+B, modulo 2^32, no overflow trap.
  - 1 SUB: A−B.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed compare. 7 SLTU: unsigned compare. Both return {31'b0, lt}.
  - 8 SLL, 9 SRL, 10 SRA: shift B by `shamt`.
  - 11 SLLV, 12 SRLV, 13 SRAV: shift B by A[4:0].
  - 14 LUI: {B[15:0], 16'h0}.
  - 16 MULT, 17 MULTU, 18 DIV, 19 DIVU: start the multiply/divide unit.
  - 20 MFHI: result = HI. 21 MFLO: result = LO.
  - 22 MTHI: HI←A. 23 MTLO: LO←A.
  - Any other code: result 0.
- Multiply/divide FSM states and transitions:
  - IDLE → BUSY when a start op is registered and the stage is not stalled. On that edge the unit latches |A|, |B| (signed ops only), the result signs and the operation kind, and clears `count`.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. `count` runs 0..31. BUSY → FIX when `count`=31.
  - FIX: negate results as required, write HI/LO, then go to IDLE.
- Result rules:
  - Multiply: HI:LO = 64-bit product.
  - Divide: LO = quotient, HI = remainder. The remainder takes the sign of the dividend.
  - Divide by zero: LO=32'hFFFFFFFF, HI=dividend.
- `stall_out` = (state≠IDLE) AND the registered op ∈ {16..23}. Otherwise `stall_out`=0; ALU ops keep flowing while the unit is BUSY.
- While `stall_out`=1:
  - `bundle_out`=`MEM_BUBBLE`, `write_reg_out`=0.
  - `address_out`, `reg_b_out` and `pc_seq_out` reflect the held registers.
- Start ops themselves go downstream with their decoded bundle. Decode assigns them `write_reg`=0.

## Timing
- Reset values:
  - Input registers clear to 0; `bundle` register to `MEM_BUBBLE`.
  - Therefore: `address_out`=0, `reg_b_out`=0, `bundle_out`=8'h31, `write_reg_out`=0, `pc_seq_out`=0, `stall_out`=0.
  - HI=LO=0; state=IDLE.
- ALU latency: one cycle, from the input capture edge to valid outputs.
- Multiply/divide latency: start op registered at cycle T → BUSY during T+1..T+32 → FIX at T+33 → HI/LO valid and IDLE at T+34.
  - An MFLO registered at T+1 stalls 33 cycles and outputs the new LO at T+34.
- MTHI/MTLO while IDLE take effect at the next edge. An MTHI/MTLO arriving while BUSY stalls, so the FIX write never collides with it.
- Reset during BUSY or FIX aborts the operation: IDLE, HI=LO=0.
- Back-to-back start ops: the second stalls until IDLE, then starts at T+34.

## Configuration
- `MULDIV_EN` defined:
  - FSM, HI/LO and `muldiv_unit` are instantiated.
  - All behaviour above applies.
- `MULDIV_EN` not defined:
  - Codes 16..23 produce result 0 and have no other effect.
  - No HI/LO storage.
  - `stall_out` is tied to 0.

## Structure
- Shared package holds:
  - the `alu_op` encoding constants;
  - the FSM state enum (IDLE, BUSY, FIX);
  - the `MEM_BUBBLE` default.
- One sub-module, `muldiv_unit`:
  - contains the FSM, `count`, the iteration datapath and HI/LO;
  - exposes `start`, `op`, `a`, `b`, `busy`, `hi`, `lo`, `mthi`, `mtlo`.
- The ALU, operand mux and stall/bubble logic stay in `execute_stage`.

## Test plan
- Reset held two cycles → every output at its reset value, including `bundle_out`=8'h31 and `stall_out`=0.
- ADD A=32'h7FFFFFFF, B=1 → `address_out`=32'h80000000. SLT A=-1, B=1 → 1. SLTU with the same operands → 0. SRA B=32'h80000000, `shamt`=4 → 32'hF8000000.
- MULT A=-3, B=7, then MFLO at T+1 → `stall_out` high for 33 cycles and `bundle_out`=8'h31 during the stall; at T+34 `address_out`=32'hFFFFFFEB. MFHI afterwards → 32'hFFFFFFFF.
- DIV A=-7, B=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU A=5, B=0 → LO=32'hFFFFFFFF, HI=5.
- MULTU followed by 20 independent ADDs → no stall, all ADD results correct. Reset asserted at T+10 → HI=LO=0 and `stall_out`=0 after the reset edge.
- With `MULDIV_EN` undefined: MULT, then MFLO → no stall, `address_out`=0.
